// File: rtl/axis_dac_feeder_pkg.sv
// Shared types and constants for the AXI-Stream to DAC sample feeder.
package axis_dac_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [3:0] KEEP_BOTH  = 4'hF;
    localparam logic [3:0] KEEP_LANE0 = 4'h3;

endpackage

// File: rtl/axis_dac_feeder_if.sv
// AXI-Stream sample bus. A beat transfers on a posedge where tvalid && tready;
// the master holds its payload stable while tvalid is high and tready is low.
interface axis_dac_feeder_if #(
    parameter int DATA_SIZE = 32,
    parameter int ID_SIZE   = 4
) ();
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [DATA_SIZE-1:0]   tdata;
    logic [ID_SIZE-1:0]     tid;
    logic [DATA_SIZE/8-1:0] tkeep;
    logic [DATA_SIZE/8-1:0] tstrb;

    modport master (output tvalid, tlast, tdata, tid, tkeep, tstrb, input tready);
    modport slave  (input tvalid, tlast, tdata, tid, tkeep, tstrb, output tready);
endinterface

// File: rtl/axis_dac_feeder_sync_fifo.sv
// Single-clock FIFO with a level counter; dout shows the head entry combinationally.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    // A pop frees the slot, so a push into a full FIFO is legal alongside it.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/axis_dac_feeder.sv
// Buffers AXI-Stream beats and plays them out to a DAC as 16-bit samples,
// lane0 then lane1, one sample per programmable rate tick.
module axis_dac_feeder
    import axis_dac_feeder_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int ID_SIZE     = 4,
    parameter int SAMPLE_SIZE = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    axis_dac_feeder_if.slave       s,
    input  logic                   enable,
    input  logic [15:0]            rate_div,
    output logic [SAMPLE_SIZE-1:0] dac_data,
    output logic                   dac_wr,
    output logic                   underrun,
    output logic [15:0]            pkt_cnt,
    output state_t                 dbg_state_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = DATA_SIZE + 1;

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, div_q, pkt_cnt_q;
    logic                   lane_q, tready_q, dac_wr_q, underrun_q;
    logic [SAMPLE_SIZE-1:0] dac_data_q, cur_sample;

    logic          accept, keep_both, keep_lane0, fifo_push, fifo_pop;
    logic          fifo_full, fifo_empty, tick, sample_ok, last_lane;
    logic [FW-1:0] fifo_din, fifo_dout;
    logic [LW-1:0] fifo_level, level_nxt;
    logic          unused_sideband;

    assign unused_sideband = ^{s.tid, s.tstrb, fifo_full};

    // Beats with an unsupported tkeep are consumed but never stored.
    assign accept     = s.tvalid && tready_q;
    assign keep_both  = (s.tkeep == KEEP_BOTH);
    assign keep_lane0 = (s.tkeep == KEEP_LANE0);
    assign fifo_push  = accept && (keep_both || keep_lane0);
    assign fifo_din   = {keep_lane0, s.tdata};

    assign tick       = (state_q == RUN) && (cnt_q == div_q);
    assign sample_ok  = tick && !fifo_empty;
    assign last_lane  = lane_q || fifo_dout[DATA_SIZE];
    assign fifo_pop   = sample_ok && last_lane;
    assign cur_sample = lane_q ? fifo_dout[DATA_SIZE-1:SAMPLE_SIZE]
                               : fifo_dout[SAMPLE_SIZE-1:0];
    assign level_nxt  = fifo_level + LW'(fifo_push) - LW'(fifo_pop);

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .aclk     (aclk),
        .areset_n (areset_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (fifo_din),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = PRIME;
            PRIME:   if (!enable) state_d = IDLE;
                     else if (fifo_level >= LW'(PRIME_LEVEL)) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            lane_q     <= 1'b0;
            tready_q   <= 1'b0;
            dac_data_q <= '0;
            dac_wr_q   <= 1'b0;
            underrun_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            // Look-ahead on the next level so tready drops on the filling edge.
            tready_q <= (level_nxt != LW'(FIFO_DEPTH));
            if (accept && s.tlast) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            // The divider is only re-sampled at a wrap or while not running.
            if (state_q != RUN || tick) begin
                cnt_q <= '0;
                div_q <= rate_div;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            dac_wr_q <= sample_ok;
            if (sample_ok) begin
                dac_data_q <= cur_sample;
                lane_q     <= !last_lane;
            end
            if (state_d == IDLE)         underrun_q <= 1'b0;
            else if (tick && fifo_empty) underrun_q <= 1'b1;
        end
    end

    assign s.tready    = tready_q;
    assign dac_data    = dac_data_q;
    assign dac_wr      = dac_wr_q;
    assign underrun    = underrun_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/axis_dac_feeder.md
Name: axis_dac_feeder

Overview:
- Downstream consumer of the team's AXI-Stream sample interface (DATA_SIZE=32, ID_SIZE=4).
- Buffers incoming beats in a FIFO and splits each 32-bit beat into two 16-bit samples.
- Outputs the samples to the DAC parallel port at a programmable rate, one sample per rate tick.
- Sits between the stream source (DMA or testbench driver) and the DAC pin interface.
- Flags underrun and counts completed packets (tlast beats).

Parameters:
- DATA_SIZE, 32: AXI-Stream tdata width; must equal 2*SAMPLE_SIZE.
- ID_SIZE, 4: tid width; accepted and ignored.
- SAMPLE_SIZE, 16: DAC sample width.
- FIFO_DEPTH, 16: beat FIFO depth; power of two, at least 4.
- PRIME_LEVEL, 4: beats buffered before output starts; 1 to FIFO_DEPTH.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  reset: synchronous, active-low.
- s_tvalid  in  1  AXI-Stream valid.
- s_tready  out  1  AXI-Stream ready.
- s_tlast  in  1  end-of-packet marker.
- s_tdata  in  DATA_SIZE  two samples: [15:0] is lane0 (sent first), [31:16] is lane1.
- s_tid  in  ID_SIZE  ignored.
- s_tkeep  in  DATA_SIZE/8  byte enables. 4'hF means two samples; 4'h3 means lane0 only; any other value means beat dropped.
- s_tstrb  in  DATA_SIZE/8  ignored.
- enable  in  1  start/stop output.
- rate_div  in  16  output period minus one, in aclk cycles.
- dac_data  out  SAMPLE_SIZE  sample to DAC.
- dac_wr  out  1  one-cycle strobe; dac_data is valid while it is high.
- underrun  out  1  sticky underrun flag.
- pkt_cnt  out  16  count of tlast beats accepted; wraps.

Behaviour:
- Reset (areset_n=0 at a posedge) forces:
  - s_tready=0, dac_data=0, dac_wr=0, underrun=0, pkt_cnt=0.
  - FIFO emptied, rate counter=0, state=IDLE.
- Reset mid-packet discards all buffered data; no partial sample is output afterwards.
- Input handshake:
  - s_tready = !fifo_full. It is registered and deasserts in the same cycle the FIFO becomes full.
  - A beat is accepted when s_tvalid && s_tready at a posedge.
  - An accepted beat is readable from the FIFO one cycle later.
  - Beats with an invalid tkeep are accepted but not written to the FIFO. Their tlast still increments pkt_cnt.
  - pkt_cnt increments on an accepted beat with s_tlast=1, wraps 0xFFFF->0, and is independent of enable.
- Rate tick:
  - A 16-bit counter counts 0..rate_div, then returns to 0; tick fires on the cycle it equals rate_div.
  - rate_div=0 gives a tick every cycle.
  - The counter resets to 0 whenever state is not RUN.
  - A rate_div change takes effect at the next wrap.
- State machine (enum, shared package):
  - IDLE: enable=1 -> PRIME.
  - PRIME: FIFO level >= PRIME_LEVEL -> RUN. enable=0 -> IDLE.
  - RUN: sample output on each tick. enable=0 -> IDLE.
  - Entering IDLE clears underrun. The FIFO is not flushed and dac_data holds its value.
- Output in RUN:
  - On a tick with a sample available: dac_data = current lane and dac_wr=1 for exactly one cycle.
  - The lane pointer alternates lane0 then lane1. A beat is popped after its last valid lane (lane0 for tkeep=4'h3).
  - Tick with no sample available: dac_wr=0, dac_data holds, underrun=1 (sticky), state stays RUN.
  - Output resumes on the next tick once data arrives; no re-prime.
- Timing and simultaneous events:
  - Latency from tick to dac_wr/dac_data is one registered cycle.
  - Push and pop on the same cycle are both honoured and the level is unchanged. A simultaneous push and pop while full is allowed because the pop frees the slot.

Decomposition:
- axis_dac_feeder_pkg: state_t {IDLE, PRIME, RUN}, KEEP_BOTH=4'hF, KEEP_LANE0=4'h3.
- Sub-module sync_fifo (WIDTH, DEPTH):
  - push, pop, din, dout, full, empty, level.
  - Synchronous active-low reset named areset_n.
  - Depth tracking via a level counter.

Test Plan:
- Reset mid-packet:
  - Send 3 beats, assert areset_n=0 for 1 cycle, then send 0x0004_0003 with PRIME_LEVEL=1.
  - Required: outputs 0x0003 then 0x0004 only; pkt_cnt=0 after reset.
- Basic order with rate_div=3, enable=1:
  - Send 4 beats 0x0002_0001 .. 0x0008_0007.
  - Required: dac_wr fires every 4 cycles with 0x0001 through 0x0008 in order; underrun=0.
- Back-pressure with enable=0:
  - Send 20 beats; s_tready drops after 16 accepted.
  - After enable=1 and rate_div=0: all 40 samples emitted in order, none lost.
- tkeep handling:
  - Send beats with tkeep 4'h3 (0xAAAA_1111), 4'h1 (dropped), 4'hF (0x3333_2222).
  - Required output: 0x1111, 0x2222, 0x3333.
- Underrun:
  - Send 4 beats with rate_div=0; after 8 samples underrun=1 and dac_wr=0.
  - New beat 0x000A_0009: outputs 0x0009, 0x000A while underrun stays 1.
  - enable=0 clears underrun.
- Packet count:
  - Send 3 packets of 2 beats with tlast on the second beat.
  - Required: pkt_cnt=3.
